branch_target_unit: RTL and testbench
=====================================

# branch_target_unit

Pipelined branch target and return address generator for the fetch/decode boundary. It computes the return address `R = B_PC + 8` and the PA-RISC branch target `TA` for 12-bit and 17-bit displacement formats, with any PC width. An optional return-address stack (RAS) predicts the targets of returns. Results are registered behind a valid/ready handshake, and a flush input clears all speculative state.

## Interface
- `PC_W`, default 8: width of PC, `TA` and `R`.
- `RAS_DEPTH`, default 4: RAS entries (power of two, ≥2).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset. Asynchronous and active-low.
- `flush`  in  1  synchronous flush: clears RAS and drops the output register.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `op`  in  2  operation: 00 BR, 01 CALL, 10 RET, 11 NOP.
- `B_PC`  in  PC_W  front PC of the branch.
- `offset`  in  21  raw instruction displacement field.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `TA`  out  PC_W  target address.
- `R`  out  PC_W  return address.
- `ras_miss`  out  1  RET found the RAS empty, so `TA` fell back to `R`.
- `ras_ovf`  out  1  sticky flag: a CALL overwrote the oldest RAS entry.

## Operation
- All arithmetic is modulo 2^PC_W. Sign-extend to PC_W, then truncate.
- `R = B_PC + 8`.
- Displacement format:
  - `offset[15:13] == 3'b000`: 17-bit `disp = {offset[20:16], offset[12:2], offset[0]}`.
  - Otherwise: 12-bit `disp = {offset[12:2], offset[0]}`.
- `TA = R + (sext(disp) << 2)` for BR and CALL.
- Per-op behaviour:
  - BR: produces `TA` and `R` only.
  - CALL: same as BR, and also pushes `R` onto the RAS.
  - RET: if the RAS is non-empty, `TA = top` and the top entry is popped. If it is empty, `TA = R` and `ras_miss = 1`.
  - NOP: `TA = R`, no RAS effect.
- RAS is a circular buffer with pointer `top` and counter `count` (0..RAS_DEPTH).
  - Push when full: write to the oldest slot, `top` wraps, `count` stays at RAS_DEPTH, `ras_ovf` is set.
  - `ras_ovf` clears only on reset or flush.
- The RAS updates only on an accepted request (`in_valid & in_ready`). Rejected requests have no side effects.
- Output register: one-entry pipeline stage, `in_ready = !flush & (!out_valid | out_ready)`.
- Flush:
  - RAS: `count = 0`, `top = 0`, `ras_ovf = 0`.
  - Output register: `out_valid = 0`.
  - Input: not accepted that cycle. Flush beats any simultaneous request.
- Reset (asynchronous): `out_valid = 0`, `TA = 0`, `R = 0`, `ras_miss = 0`, `ras_ovf = 0`, `count = 0`, `top = 0`. RAS contents are don't-care.

## Timing
- Latency: 1 cycle. A request accepted at edge N appears on `TA`/`R` with `out_valid = 1` after edge N.
- Throughput: 1 per cycle while `out_ready = 1`. Accept and drain in the same cycle are allowed.
- Stall: while `out_valid & !out_ready`, `TA`, `R` and `ras_miss` hold stable and `in_ready = 0`.
- A RET that immediately follows a CALL sees the pushed value. The RAS is written at the acceptance edge of the CALL, which comes before the RET's acceptance.
- `ras_ovf` updates at the same edge as the overwriting push.
- Reset deasserted mid-stream: behaviour restarts from the reset state, with no partial results.

## Configuration
- `BRANCH_TARGET_RAS_EN` defined: RAS logic, `ras_miss` and `ras_ovf` are built as described above.
- `BRANCH_TARGET_RAS_EN` undefined:
  - No RAS storage.
  - RET computes `TA` like BR (displacement form).
  - CALL performs no push.
  - `ras_miss` and `ras_ovf` are tied to 0.

## Test plan
- BR, 12-bit format, PC_W=8: `B_PC=0x10`, `offset[15:13]=001`, disp=3 (`offset[2]=1`, `offset[0]=1`) → `R=0x18`, `TA=0x24`. With disp=-1 (`offset[12:2]` all ones, `offset[0]=1`) → `TA=0x14`.
- Wrap-around: `B_PC=0xFC`, 12-bit disp=0 → `R=0x04`, `TA=0x04`. 17-bit format with `offset[20:16]=0x1F`, rest ones (disp=-1) → `TA=0x00`.
- CALL then RET: CALL at `B_PC=0x20` (disp 4 → `TA=0x38`), then RET at `B_PC=0x80` → `TA=0x28`, `R=0x88`, `ras_miss=0`.
- RAS overflow, RAS_DEPTH=4:
  - CALLs at `B_PC` 0x00, 0x10, 0x20, 0x30, 0x40 → `ras_ovf=1` after the fifth.
  - Five RETs at `B_PC=0x80` → `TA` = 0x48, 0x38, 0x28, 0x18, then 0x88 with `ras_miss=1`.
- Backpressure: hold `out_ready=0` for 3 cycles with `in_valid=1` and op CALL → outputs stable, `in_ready=0`, RAS `count` unchanged. Release → exactly one push per accepted request.
- Flush and reset:
  - Flush with `out_valid=1` and a pending RET → `out_valid=0` next cycle, request not accepted, next RET gives `ras_miss=1`.
  - Asynchronous `rst_n` low mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/branch_target_unit.sv
// Pipelined branch target / return address generator (PA-RISC 12/17-bit displacement formats).
// Optional return-address stack built when BRANCH_TARGET_RAS_EN is defined.
module branch_target_unit #(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [PC_W-1:0] B_PC,
  input  logic [20:0]     offset,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] TA,
  output logic [PC_W-1:0] R,
  output logic            ras_miss,
  output logic            ras_ovf
);

  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_RET  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;
  localparam int         EXT_W   = (PC_W > 19) ? PC_W : 19;

  logic                    in_ready_s;
  logic                    accept_s;
  logic [PC_W-1:0]         ret_addr_s;
  logic [16:0]             disp_raw_s;
  logic signed [EXT_W-1:0] disp_ext_s;
  logic [PC_W-1:0]         disp_target_s;
  logic [PC_W-1:0]         target_s;
  logic                    miss_s;
  logic                    unused_ok_s;

  logic                    out_valid_r;
  logic [PC_W-1:0]         ta_r;
  logic [PC_W-1:0]         r_r;
  logic                    ras_miss_r;

  assign in_ready_s  = !flush && (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign ret_addr_s  = B_PC + PC_W'(4'd8);
  // offset[1] carries no displacement information in either format
  assign unused_ok_s = ^{offset[1], disp_ext_s};

  // Displacement decode: the 12-bit form is pre-extended to 17 bits so both share one path
  always_comb begin
    disp_raw_s    = 17'd0;
    disp_ext_s    = {EXT_W{1'b0}};
    disp_target_s = {PC_W{1'b0}};
    if (offset[15:13] == 3'b000) begin
      disp_raw_s = {offset[20:16], offset[12:2], offset[0]};
    end else begin
      disp_raw_s = {{5{offset[12]}}, offset[12:2], offset[0]};
    end
    disp_ext_s    = EXT_W'($signed(disp_raw_s));
    disp_target_s = ret_addr_s + {disp_ext_s[PC_W-3:0], 2'b00};
  end

`ifdef BRANCH_TARGET_RAS_EN
  localparam int               PTR_W    = $clog2(RAS_DEPTH);
  localparam int               CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] top_r;
  logic [PTR_W-1:0] top_dec_s;
  logic [CNT_W-1:0] count_r;
  logic             ras_ovf_r;
  logic             ras_empty_s;
  logic             push_s;
  logic             pop_s;
  logic [PC_W-1:0]  ras_top_s;

  // top_r points at the next free slot; when full that slot is the oldest entry
  assign top_dec_s   = top_r - PTR_W'(1'b1);
  assign ras_top_s   = ras_mem_r[top_dec_s];
  assign ras_empty_s = (count_r == {CNT_W{1'b0}});
  assign push_s      = accept_s && (op == OP_CALL);
  assign pop_s       = accept_s && (op == OP_RET) && !ras_empty_s;
  assign ras_ovf     = ras_ovf_r;

  // RAS storage; contents are don't-care after reset/flush since count gates reads
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_mem_r[top_r] <= ret_addr_s;
    end
  end

  // RAS pointer, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_r     <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      ras_ovf_r <= 1'b0;
    end else if (flush) begin
      top_r     <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      ras_ovf_r <= 1'b0;
    end else if (push_s) begin
      top_r <= top_r + PTR_W'(1'b1);
      if (count_r == FULL_CNT) begin
        ras_ovf_r <= 1'b1;
      end else begin
        count_r <= count_r + CNT_W'(1'b1);
      end
    end else if (pop_s) begin
      top_r   <= top_dec_s;
      count_r <= count_r - CNT_W'(1'b1);
    end
  end
`else
  assign ras_ovf = 1'b0;
`endif

  // Per-op target selection
  always_comb begin
    target_s = ret_addr_s;
    miss_s   = 1'b0;
    case (op)
      OP_BR, OP_CALL: begin
        target_s = disp_target_s;
      end
      OP_RET: begin
`ifdef BRANCH_TARGET_RAS_EN
        if (ras_empty_s) begin
          target_s = ret_addr_s;
          miss_s   = 1'b1;
        end else begin
          target_s = ras_top_s;
        end
`else
        target_s = disp_target_s;
`endif
      end
      OP_NOP: begin
        target_s = ret_addr_s;
      end
      default: begin
        target_s = ret_addr_s;
      end
    endcase
  end

  // One-entry output stage; flush drops any held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      ta_r        <= {PC_W{1'b0}};
      r_r         <= {PC_W{1'b0}};
      ras_miss_r  <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      ta_r        <= target_s;
      r_r         <= ret_addr_s;
      ras_miss_r  <= miss_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign TA        = ta_r;
  assign R         = r_r;
  assign ras_miss  = ras_miss_r;

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit: directed vectors, expected results queued at acceptance.
module tb_branch_target_unit;

  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_RET  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;
`ifdef BRANCH_TARGET_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [7:0]  b_pc;
  logic [20:0] offset_v;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  ta;
  logic [7:0]  r;
  logic        ras_miss;
  logic        ras_ovf;

  typedef struct packed {
    logic [7:0] ta;
    logic [7:0] r;
    logic       miss;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  branch_target_unit #(.PC_W(8), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .B_PC(b_pc), .offset(offset_v),
    .out_valid(out_valid), .out_ready(out_ready), .TA(ta), .R(r),
    .ras_miss(ras_miss), .ras_ovf(ras_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on the output pops one expected result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got TA=0x%0h R=0x%0h expected no output", ta, r);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_TA", ta, mon_e.ta);
        chk("out_R", r, mon_e.r);
        chk("out_ras_miss", 8'(ras_miss), 8'(mon_e.miss));
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [7:0] pc, input logic [20:0] off,
                      input logic [7:0] e_ta, input logic [7:0] e_r, input logic e_miss);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    op       = o;
    b_pc     = pc;
    offset_v = off;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (got) begin
      exp_q.push_back({e_ta, e_r, e_miss});
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected acceptance");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    op        = OP_NOP;
    b_pc      = 8'h00;
    offset_v  = 21'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 8'(out_valid), 8'h00);
    chk("reset_TA", ta, 8'h00);
    chk("reset_R", r, 8'h00);
    chk("reset_ras_miss", 8'(ras_miss), 8'h00);
    chk("reset_ras_ovf", 8'(ras_ovf), 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Displacement formats and wrap-around
    send(OP_BR,  8'h10, 21'h002005, 8'h24, 8'h18, 1'b0);
    send(OP_BR,  8'h10, 21'h003FFD, 8'h14, 8'h18, 1'b0);
    send(OP_BR,  8'hFC, 21'h002000, 8'h04, 8'h04, 1'b0);
    send(OP_BR,  8'hFC, 21'h1F1FFD, 8'h00, 8'h04, 1'b0);
    send(OP_NOP, 8'h30, 21'h002005, 8'h38, 8'h38, 1'b0);

    // CALL immediately followed by RET
    send(OP_CALL, 8'h20, 21'h002008, 8'h38, 8'h28, 1'b0);
    send(OP_RET,  8'h80, 21'h000000, RAS ? 8'h28 : 8'h88, 8'h88, 1'b0);

    // Overflow: fifth CALL overwrites the oldest entry
    send(OP_CALL, 8'h00, 21'h002000, 8'h08, 8'h08, 1'b0);
    send(OP_CALL, 8'h10, 21'h002000, 8'h18, 8'h18, 1'b0);
    send(OP_CALL, 8'h20, 21'h002000, 8'h28, 8'h28, 1'b0);
    send(OP_CALL, 8'h30, 21'h002000, 8'h38, 8'h38, 1'b0);
    chk("ovf_when_just_full", 8'(ras_ovf), 8'h00);
    send(OP_CALL, 8'h40, 21'h002000, 8'h48, 8'h48, 1'b0);
    chk("ovf_after_wrap", 8'(ras_ovf), 8'(RAS));
    send(OP_RET, 8'h80, 21'h0, RAS ? 8'h48 : 8'h88, 8'h88, 1'b0);
    send(OP_RET, 8'h80, 21'h0, RAS ? 8'h38 : 8'h88, 8'h88, 1'b0);
    send(OP_RET, 8'h80, 21'h0, RAS ? 8'h28 : 8'h88, 8'h88, 1'b0);
    send(OP_RET, 8'h80, 21'h0, RAS ? 8'h18 : 8'h88, 8'h88, 1'b0);
    send(OP_RET, 8'h80, 21'h0, 8'h88, 8'h88, RAS);
    drain();
    chk("ovf_sticky", 8'(ras_ovf), 8'(RAS));

    // Backpressure: held result must stay stable while a CALL waits
    out_ready = 1'b0;
    send(OP_BR, 8'h40, 21'h002005, 8'h54, 8'h48, 1'b0);
    in_valid = 1'b1;
    op       = OP_CALL;
    b_pc     = 8'h50;
    offset_v = 21'h002000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 8'(in_ready), 8'h00);
      chk("stall_out_valid", 8'(out_valid), 8'h01);
      chk("stall_TA", ta, 8'h54);
      chk("stall_R", r, 8'h48);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(OP_CALL, 8'h50, 21'h002000, 8'h58, 8'h58, 1'b0);
    send(OP_RET,  8'h80, 21'h0, RAS ? 8'h58 : 8'h88, 8'h88, 1'b0);
    send(OP_RET,  8'h80, 21'h0, 8'h88, 8'h88, RAS);
    drain();

    // Flush while a result is held and a RET is pending
    out_ready = 1'b0;
    send(OP_CALL, 8'h00, 21'h002000, 8'h08, 8'h08, 1'b0);
    in_valid = 1'b1;
    op       = OP_RET;
    b_pc     = 8'h80;
    offset_v = 21'h0;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 8'(in_ready), 8'h00);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 8'(out_valid), 8'h00);
    chk("flush_ras_ovf", 8'(ras_ovf), 8'h00);
    out_ready = 1'b1;
    send(OP_RET, 8'h80, 21'h0, 8'h88, 8'h88, RAS);
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(OP_BR, 8'h10, 21'h002005, 8'h24, 8'h18, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 8'(out_valid), 8'h00);
    chk("async_rst_TA", ta, 8'h00);
    chk("async_rst_R", r, 8'h00);
    chk("async_rst_ras_miss", 8'(ras_miss), 8'h00);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(OP_BR, 8'h10, 21'h002005, 8'h24, 8'h18, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
